// File: rtl/fsgn_pkg.sv
// rtl/fsgn_pkg.sv - shared types, constants and NaN helper for the sign-injection slot
package fsgn_pkg;

    typedef enum logic [1:0] {
        FSGNJ    = 2'b00,
        FSGNJN   = 2'b01,
        FSGNJX   = 2'b10,
        FSGN_ILL = 2'b11
    } fsgn_op_t;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    // Signalling and quiet NaNs are deliberately not distinguished.
    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fsgn_arb_if.sv
// rtl/fsgn_arb_if.sv - two-port issue bus and registered result bus of the sign-injection slot
interface fsgn_arb_if #(
    parameter int TAG_W = 4
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][1:0]       req_op;
    logic [1:0][31:0]      req_x1;
    logic [1:0][31:0]      req_x2;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_y;
    logic                  out_exc;
    logic                  out_src;
    logic [TAG_W-1:0]      out_tag;

    modport master (
        output req_valid, req_op, req_x1, req_x2, req_tag, out_ready,
        input  req_ready, out_valid, out_y, out_exc, out_src, out_tag
    );

    modport slave (
        input  req_valid, req_op, req_x1, req_x2, req_tag, out_ready,
        output req_ready, out_valid, out_y, out_exc, out_src, out_tag
    );
endinterface

// File: rtl/fsgn_core.sv
// rtl/fsgn_core.sv - combinational fsgnj/fsgnjn/fsgnjx datapath with NaN exception
module fsgn_core
    import fsgn_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  fsgn_op_t    op,
    output logic [31:0] y,
    output logic        exception
);

    always_comb begin
        y         = {x2[31], x1[30:0]};
        exception = is_nan(x1) | is_nan(x2);
        case (op)
            FSGNJ:    y = {x2[31], x1[30:0]};
            FSGNJN:   y = {~x2[31], x1[30:0]};
            FSGNJX:   y = {x1[31] ^ x2[31], x1[30:0]};
            FSGN_ILL: begin
                y         = x1;
                exception = 1'b1;
            end
            default:  y = x1;
        endcase
    end

endmodule

// File: rtl/fsgn_arb.sv
// rtl/fsgn_arb.sv - round-robin two-port sign-injection slot with registered output (FSGN_STICKY_EN adds exc_sticky)
module fsgn_arb
    import fsgn_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rstn,
    fsgn_arb_if.slave   bus
`ifdef FSGN_STICKY_EN
    ,
    output logic        exc_sticky,
    input  logic        exc_clr
`endif
);

    logic             rr_ptr;
    logic             grant;
    logic             free;
    logic             fire;
    logic [1:0]       ready;
    logic [31:0]      core_y;
    logic             core_exc;
    logic             out_valid_q;
    logic [31:0]      out_y_q;
    logic             out_exc_q;
    logic             out_src_q;
    logic [TAG_W-1:0] out_tag_q;

    // Grant looks only at valids and the pointer, never at op or data.
    always_comb begin
        grant = (&bus.req_valid) ? rr_ptr : bus.req_valid[1];
        free  = !out_valid_q || bus.out_ready;
        ready = 2'b00;
        if (free && (|bus.req_valid)) begin
            ready = grant ? 2'b10 : 2'b01;
        end
        fire = |(bus.req_valid & ready);
    end

    fsgn_core u_core (
        .x1        (bus.req_x1[grant]),
        .x2        (bus.req_x2[grant]),
        .op        (fsgn_op_t'(bus.req_op[grant])),
        .y         (core_y),
        .exception (core_exc)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_y_q     <= 32'd0;
            out_exc_q   <= 1'b0;
            out_src_q   <= 1'b0;
            out_tag_q   <= '0;
            rr_ptr      <= 1'b0;
        end else if (fire) begin
            // A drain and a new accept in the same cycle simply overwrite the register.
            out_valid_q <= 1'b1;
            out_y_q     <= core_y;
            out_exc_q   <= core_exc;
            out_src_q   <= grant;
            out_tag_q   <= bus.req_tag[grant];
            rr_ptr      <= ~grant;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef FSGN_STICKY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exc_sticky <= 1'b0;
        end else if (out_valid_q && bus.out_ready && out_exc_q) begin
            exc_sticky <= 1'b1;
        end else if (exc_clr) begin
            exc_sticky <= 1'b0;
        end
    end
`endif

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_exc   = out_exc_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_fsgn_arb.sv
// tb/tb_fsgn_arb.sv - scoreboard bench for fsgn_arb: directed ops, fairness, backpressure, reset, sticky flag
module tb_fsgn_arb;

    typedef struct packed {
        logic [31:0] y;
        logic        exc;
        logic        src;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;
    exp_t sb[$];
    logic [31:0] cur_y[2];
    logic        cur_exc[2];
`ifdef FSGN_STICKY_EN
    logic exc_sticky;
    logic exc_clr;
`endif

    fsgn_arb_if #(.TAG_W(4)) bus ();

    fsgn_arb #(.TAG_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus.slave)
`ifdef FSGN_STICKY_EN
        ,
        .exc_sticky (exc_sticky),
        .exc_clr    (exc_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue monitor: every request handshake queues the hand-computed result for that port.
    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 2; k++) begin
                if (bus.req_valid[k] && bus.req_ready[k]) begin
                    sb.push_back('{y: cur_y[k], exc: cur_exc[k], src: k[0], tag: bus.req_tag[k]});
                end
            end
        end
    end

    // Result monitor: every output handshake is compared against the queue head.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {bus.out_y, bus.out_exc, bus.out_src, bus.out_tag}, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {bus.out_y, bus.out_exc, bus.out_src, bus.out_tag}, e);
            end
        end
    end

    task automatic drive(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] ey, input logic ee);
        bus.req_op[k]  = op;
        bus.req_x1[k]  = a;
        bus.req_x2[k]  = b;
        bus.req_tag[k] = tag;
        cur_y[k]       = ey;
        cur_exc[k]     = ee;
        bus.req_valid[k] = 1'b1;
    endtask

    // Single-port issue with out_ready held high; returns one cycle after the handshake.
    task automatic issue(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] ey, input logic ee);
        int n;
        @(posedge clk) #1;
        drive(k, op, a, b, tag, ey, ee);
        n = 0;
        @(negedge clk);
        while (!bus.req_ready[k] && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check("issue_timeout", 64'd0, 64'd1);
        @(posedge clk) #1;
        bus.req_valid[k] = 1'b0;
        check("latency_valid", {63'd0, bus.out_valid}, 64'd1);
        check("latency_tag", {60'd0, bus.out_tag}, {60'd0, tag});
        check("latency_src", {63'd0, bus.out_src}, k);
    endtask

    initial begin
        int cnt[2];
        int g;
        logic [3:0] next_tag;
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_op    = '0;
        bus.req_x1    = '0;
        bus.req_x2    = '0;
        bus.req_tag   = '0;
        bus.out_ready = 1'b1;
        cur_y[0] = '0; cur_y[1] = '0; cur_exc[0] = 1'b0; cur_exc[1] = 1'b0;
`ifdef FSGN_STICKY_EN
        exc_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_y", {32'd0, bus.out_y}, 64'd0);
        check("rst_out_exc", {63'd0, bus.out_exc}, 64'd0);
        check("rst_out_src", {63'd0, bus.out_src}, 64'd0);
        check("rst_out_tag", {60'd0, bus.out_tag}, 64'd0);
        check("rst_req_ready", {62'd0, bus.req_ready}, 64'd0);
`ifdef FSGN_STICKY_EN
        check("rst_sticky", {63'd0, exc_sticky}, 64'd0);
`endif
        @(posedge clk) #1;
        rstn = 1'b1;

        // Directed single ops.
        issue(0, 2'b01, 32'h3F800000, 32'h40000000, 4'd5, 32'hBF800000, 1'b0);
        issue(1, 2'b10, 32'hC0400000, 32'h80000000, 4'd6, 32'h40400000, 1'b0);
        issue(0, 2'b00, 32'h7F800000, 32'h80000000, 4'd7, 32'hFF800000, 1'b0);
        issue(1, 2'b00, 32'h3F800000, 32'h7FC00000, 4'd8, 32'h3F800000, 1'b1);
        issue(0, 2'b01, 32'h7FC00001, 32'h00000000, 4'd9, 32'hFFC00001, 1'b1);
        issue(1, 2'b11, 32'h12345678, 32'h00000000, 4'd10, 32'h12345678, 1'b1);
        issue(0, 2'b10, 32'hFF800001, 32'h80000000, 4'd11, 32'h7F800001, 1'b1);

        // Backpressure: last handshake was port 0, so port 1 wins the tie.
        @(posedge clk) #1;
        bus.out_ready = 1'b0;
        drive(0, 2'b00, 32'h3F800000, 32'hC0000000, 4'd1, 32'hBF800000, 1'b0);
        drive(1, 2'b01, 32'h40000000, 32'h40000000, 4'd2, 32'hC0000000, 1'b0);
        @(negedge clk);
        check("bp_first_grant", {62'd0, bus.req_ready}, 64'd2);
        @(posedge clk) #1;
        bus.req_tag[1] = 4'd3;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_req_ready", {62'd0, bus.req_ready}, 64'd0);
            check("bp_hold", {bus.out_valid, bus.out_y, bus.out_src, bus.out_tag},
                  {1'b1, 32'hC0000000, 1'b1, 4'd2});
        end
        @(posedge clk) #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", {62'd0, bus.req_ready}, 64'd1);
        @(posedge clk) #1;
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);

        // Asynchronous reset while a result is held.
        #1;
        bus.out_ready = 1'b0;
        drive(0, 2'b00, 32'h3F800000, 32'h3F800000, 4'd7, 32'h3F800000, 1'b0);
        @(negedge clk);
        check("rst_pre_grant", {62'd0, bus.req_ready}, 64'd1);
        @(posedge clk) #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("rst_pre_valid", {63'd0, bus.out_valid}, 64'd1);
        #1 rstn = 1'b0;
        #1;
        check("rst_async_drop", {63'd0, bus.out_valid}, 64'd0);
        sb.delete();

        // Fairness from reset with both ports continuously valid.
        @(posedge clk) #1;
        bus.out_ready = 1'b1;
        drive(0, 2'b00, 32'h3F800000, 32'h40000000, 4'd0, 32'h3F800000, 1'b0);
        drive(1, 2'b01, 32'h3F800000, 32'h40000000, 4'd1, 32'hBF800000, 1'b0);
        rstn = 1'b1;
        next_tag = 4'd2;
        cnt[0] = 0; cnt[1] = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("fair_grant", {62'd0, bus.req_ready}, (c % 2 == 0) ? 64'd1 : 64'd2);
            g = bus.req_ready[1] ? 1 : 0;
            if (bus.req_ready != 2'b00) cnt[g]++;
            @(posedge clk) #1;
            bus.req_tag[g] = next_tag;
            next_tag++;
        end
        bus.req_valid = 2'b00;
        check("fair_cnt0", cnt[0], 64'd50);
        check("fair_cnt1", cnt[1], 64'd50);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 64'd0);

`ifdef FSGN_STICKY_EN
        issue(0, 2'b00, 32'h3F800000, 32'h7FC00000, 4'd3, 32'h3F800000, 1'b1);
        @(posedge clk) #1;
        check("sticky_set", {63'd0, exc_sticky}, 64'd1);
        issue(1, 2'b00, 32'h3F800000, 32'h3F800000, 4'd4, 32'h3F800000, 1'b0);
        @(posedge clk) #1;
        check("sticky_hold", {63'd0, exc_sticky}, 64'd1);
        exc_clr = 1'b1;
        @(posedge clk) #1;
        exc_clr = 1'b0;
        check("sticky_clr", {63'd0, exc_sticky}, 64'd0);
        issue(0, 2'b11, 32'h00000001, 32'h0, 4'd5, 32'h00000001, 1'b1);
        exc_clr = 1'b1;
        @(posedge clk) #1;
        exc_clr = 1'b0;
        check("sticky_set_wins", {63'd0, exc_sticky}, 64'd1);
        repeat (2) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
